// File: rtl/n_restoring_divider_pkg.sv
//------------------------------------------------------------------------------
// n_restoring_divider_pkg
// FSM state encodings and the counter-width helper for the restoring divider.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package n_restoring_divider_pkg;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    function automatic int cnt_width(input int bits);
        return (bits < 2) ? 1 : $clog2(bits);
    endfunction

endpackage

`default_nettype wire

// File: rtl/n_restoring_divider_subtractor.sv
//------------------------------------------------------------------------------
// n_ripple_borrow_subtractor
// Combinational a - b as a ripple chain of full_adder cells (b inverted, ci=1).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module n_ripple_borrow_subtractor #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    logic [WIDTH:0] w_c;

    assign w_c[0] = 1'b1;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            full_adder u_fa (
                .a  (a[i]),
                .b  (~b[i]),
                .ci (w_c[i]),
                .s  (diff[i]),
                .co (w_c[i+1])
            );
        end
    endgenerate

    // No final carry means the two's-complement add wrapped below zero.
    assign borrow = ~w_c[WIDTH];
endmodule

`default_nettype wire

// File: rtl/n_restoring_divider.sv
//------------------------------------------------------------------------------
// n_restoring_divider
// Sequential unsigned restoring divider, one quotient bit per clock.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module n_restoring_divider
    import n_restoring_divider_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [BITS-1:0] dividend,
    input  logic [BITS-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] quotient,
    output logic [BITS-1:0] remainder,
    output logic            div_by_zero
);
    localparam int              c_CW       = cnt_width(BITS);
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(BITS - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [c_CW-1:0] r_cnt;
    logic [BITS:0]   r_r;
    logic [BITS-1:0] r_q;
    logic [BITS-1:0] r_d;

    logic [BITS:0]   w_s;
    logic [BITS:0]   w_t;
    logic            w_borrow;
    logic [BITS:0]   w_r_next;
    logic [BITS-1:0] w_q_next;
    logic            w_accept;
    logic            w_unused;

    assign w_accept = start && ((r_state == c_IDLE) || (r_state == c_DONE));

    assign w_s = {r_r[BITS-1:0], r_q[BITS-1]};

    n_ripple_borrow_subtractor #(
        .WIDTH (BITS + 1)
    ) u_sub (
        .a      (w_s),
        .b      ({1'b0, r_d}),
        .diff   (w_t),
        .borrow (w_borrow)
    );

    assign w_r_next = w_borrow ? w_s : w_t;
    assign w_q_next = {r_q[BITS-2:0], ~w_borrow};

    // R < D keeps the headroom bit of R at zero, so it is never read back.
    assign w_unused = r_r[BITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (start) begin
                    w_next = (divisor == '0) ? c_DONE : c_RUN;
                end else begin
                    w_next = c_IDLE;
                end
            end
            c_RUN: begin
                if (r_cnt == '0) begin
                    w_next = c_DONE;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_RUN);
        done = (r_state == c_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_q   <= dividend;
            r_d   <= divisor;
            r_r   <= '0;
            r_cnt <= c_CNT_LOAD;
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (r_state == c_RUN) begin
            r_q <= w_q_next;
            r_r <= w_r_next;
            if (r_cnt == '0) begin
                quotient    <= w_q_next;
                remainder   <= w_r_next[BITS-1:0];
                div_by_zero <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end
endmodule

`default_nettype wire
